// File: rtl/fire_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : fire_scheduler_if
// Purpose  : Bundle carrying scheduling controls in and the chosen transition
//            index, override flag and selection count out.
// Revision : 1.0 - initial release
// ============================================================================
interface fire_scheduler_if #(
  parameter int N  = 4,
  parameter int FW = $clog2(N + 2)
);
  logic          go;
  logic          mode;
  logic [N-1:0]  enabled;
  logic [FW-1:0] fire;
  logic          forced;
  logic [31:0]   fire_count;

  // Environment side: drives controls, observes the selection
  modport master (
    output go, mode, enabled,
    input  fire, forced, fire_count
  );

  // Scheduler side
  modport slave (
    input  go, mode, enabled,
    output fire, forced, fire_count
  );
endinterface
`default_nettype wire

// File: rtl/fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fire_scheduler
// Purpose  : Registered, starvation-free choice of one enabled transition per
//            cycle (round-robin or LFSR start point, with an age override).
// Revision : 1.0 - initial release
// ============================================================================
module fire_scheduler #(
  parameter int          N        = 4,
  parameter int          FW       = $clog2(N + 2),
  parameter int          MAX_WAIT = 8,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input wire clk,
  input wire reset,
  fire_scheduler_if.slave bus
);

  localparam int              PW          = (N > 1) ? $clog2(N) : 1;
  localparam int              AW          = $clog2(MAX_WAIT + 1);
  localparam logic [FW-1:0]   c_IDLE      = FW'(N + 1);
  localparam logic [FW-1:0]   c_LAST      = FW'(N - 1);
  localparam logic [15:0]     c_SEED_INIT = (SEED == 16'd0) ? 16'd1 : SEED;
  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0]     c_TAPS      = 16'hB400;
  localparam logic [AW-1:0]   c_MAX_AGE   = AW'(MAX_WAIT);

  logic [FW-1:0]  r_fire;
  logic           r_forced;
  logic [PW-1:0]  r_ptr;
  logic [15:0]    r_lfsr;
  logic [31:0]    r_count;

  logic [N-1:0]   w_due;
  logic           w_active;
  logic [PW-1:0]  w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW:0]    w_sum;
  logic           w_found;
  logic [FW-1:0]  w_sel;
  logic           w_sel_forced;
  logic [PW-1:0]  w_ptr_nxt;
  logic [15:0]    w_lfsr_nxt;

  assign w_active   = bus.go && (|bus.enabled);
  // In random mode the scan starts from the pre-advance LFSR value
  assign w_start    = bus.mode ? PW'(r_lfsr % 16'(N)) : r_ptr;
  // Rotating a doubled copy puts index w_start at bit 0 of w_rot
  assign w_dbl      = {bus.enabled, bus.enabled};
  assign w_rot      = N'(w_dbl >> w_start);
  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_TAPS : 16'd0);
  assign w_ptr_nxt  = (w_sel == c_LAST) ? '0 : PW'(w_sel + FW'(1));

  // Selection: idle gate, then lowest overdue transition, then circular scan
  always_comb begin
    w_sel        = c_IDLE;
    w_sel_forced = 1'b0;
    w_found      = 1'b0;
    w_sum        = '0;
    if (w_active) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && w_due[i]) begin
          w_sel        = FW'(i);
          w_sel_forced = 1'b1;
          w_found      = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!w_found && w_rot[i]) begin
          w_sum = {1'b0, w_start} + (PW + 1)'(i);
          if (w_sum >= (PW + 1)'(N)) begin
            w_sum = w_sum - (PW + 1)'(N);
          end
          w_sel   = FW'(w_sum);
          w_found = 1'b1;
        end
      end
    end
  end

  // Registered selection, pointer, LFSR and selection counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fire   <= c_IDLE;
      r_forced <= 1'b0;
      r_ptr    <= '0;
      r_lfsr   <= c_SEED_INIT;
      r_count  <= '0;
    end else begin
      r_lfsr   <= w_lfsr_nxt;
      r_fire   <= w_sel;
      r_forced <= w_sel_forced;
      if (w_sel != c_IDLE) begin
        r_ptr   <= w_ptr_nxt;
        r_count <= r_count + 32'd1;
      end
    end
  end

  // Per-transition wait counters; they keep counting while go is low
  for (genvar gi = 0; gi < N; gi++) begin : g_age
    logic [AW-1:0] r_age;

    assign w_due[gi] = bus.enabled[gi] && (r_age == c_MAX_AGE);

    // Clear on selection or disable, otherwise saturate at MAX_WAIT
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_age <= '0;
      end else if ((w_sel == FW'(gi)) || !bus.enabled[gi]) begin
        r_age <= '0;
      end else if (r_age != c_MAX_AGE) begin
        r_age <= r_age + AW'(1);
      end
    end
  end

  assign bus.fire       = r_fire;
  assign bus.forced     = r_forced;
  assign bus.fire_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fire_scheduler
// Purpose  : Directed self-checking bench for fire_scheduler (N=4), one
//            instance with MAX_WAIT=8 and one with MAX_WAIT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fire_scheduler;

  logic clk     = 1'b0;
  logic reset_a = 1'b0;
  logic reset_b = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  fire_scheduler_if #(.N(4)) bus_a ();
  fire_scheduler_if #(.N(4)) bus_b ();

  fire_scheduler #(.N(4), .MAX_WAIT(8)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.slave)
  );

  fire_scheduler #(.N(4), .MAX_WAIT(2)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.go = 1'b1; bus_a.mode = 1'b0; bus_a.enabled = 4'b1011;
    bus_b.go = 1'b0; bus_b.mode = 1'b0; bus_b.enabled = 4'b0000;
    repeat (3) tick();
    checks++;
    if (bus_a.fire !== 3'd5) begin
      errors++; $display("FAIL reset_fire: got %0d expected 5", bus_a.fire);
    end
    checks++;
    if (bus_a.forced !== 1'b0) begin
      errors++; $display("FAIL reset_forced: got %0d expected 0", bus_a.forced);
    end
    checks++;
    if (bus_a.fire_count !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus_a.fire_count);
    end
    bus_a.enabled = 4'b0000;
    @(negedge clk);
    reset_a = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (bus_a.fire !== 3'd5) begin
        errors++; $display("FAIL release_idle[%0d]: got %0d expected 5", k, bus_a.fire);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
    bus_a.go = 1'b1; bus_a.mode = 1'b0; bus_a.enabled = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bus_a.fire !== 3'(exp_rr[k])) begin
        errors++; $display("FAIL rr_fire[%0d]: got %0d expected %0d", k, bus_a.fire, exp_rr[k]);
      end
      checks++;
      if (bus_a.forced !== 1'b0) begin
        errors++; $display("FAIL rr_forced[%0d]: got %0d expected 0", k, bus_a.forced);
      end
      checks++;
      if (bus_a.fire_count !== 32'(k + 1)) begin
        errors++; $display("FAIL rr_count[%0d]: got %0d expected %0d", k, bus_a.fire_count, k + 1);
      end
    end
  endtask

  task automatic test_skip_wrap();
    int exp_sw [4] = '{3, 0, 3, 0};
    // Land the pointer on 1 by selecting transition 0 alone
    bus_a.enabled = 4'b0001;
    tick();
    checks++;
    if (bus_a.fire !== 3'd0) begin
      errors++; $display("FAIL skip_setup: got %0d expected 0", bus_a.fire);
    end
    bus_a.enabled = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus_a.fire !== 3'(exp_sw[k])) begin
        errors++; $display("FAIL skip_fire[%0d]: got %0d expected %0d", k, bus_a.fire, exp_sw[k]);
      end
    end
    checks++;
    if (bus_a.fire_count !== 32'd11) begin
      errors++; $display("FAIL skip_count: got %0d expected 11", bus_a.fire_count);
    end
  endtask

  task automatic test_async_reset();
    bus_a.enabled = 4'b1111;
    tick();
    checks++;
    if (bus_a.fire !== 3'd1) begin
      errors++; $display("FAIL areset_pre: got %0d expected 1", bus_a.fire);
    end
    #2;
    reset_a = 1'b0;
    #1;
    checks++;
    if (bus_a.fire !== 3'd5) begin
      errors++; $display("FAIL areset_fire: got %0d expected 5", bus_a.fire);
    end
    checks++;
    if (bus_a.fire_count !== 32'd0) begin
      errors++; $display("FAIL areset_count: got %0d expected 0", bus_a.fire_count);
    end
    @(negedge clk);
    reset_a = 1'b1;
    tick();
    checks++;
    if (bus_a.fire !== 3'd0) begin
      errors++; $display("FAIL areset_restart0: got %0d expected 0", bus_a.fire);
    end
    tick();
    checks++;
    if (bus_a.fire !== 3'd1) begin
      errors++; $display("FAIL areset_restart1: got %0d expected 1", bus_a.fire);
    end
  endtask

  task automatic test_starvation();
    // Seed 16'hACE1: starts 1 then 0, so 2 and 3 age out together
    int exp_f [4] = '{1, 0, 2, 1};
    int exp_o [4] = '{0, 0, 1, 1};
    bus_b.go = 1'b1; bus_b.mode = 1'b1; bus_b.enabled = 4'b1111;
    @(negedge clk);
    reset_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (bus_b.fire !== 3'(exp_f[k])) begin
        errors++; $display("FAIL starve_fire[%0d]: got %0d expected %0d", k, bus_b.fire, exp_f[k]);
      end
      checks++;
      if (bus_b.forced !== 1'(exp_o[k])) begin
        errors++; $display("FAIL starve_forced[%0d]: got %0d expected %0d", k, bus_b.forced, exp_o[k]);
      end
      if (k == 2) begin
        checks++;
        if (dut_b.g_age[2].r_age !== 2'd0) begin
          errors++; $display("FAIL starve_age2: got %0d expected 0", dut_b.g_age[2].r_age);
        end
      end
    end
  endtask

  task automatic test_go_gating();
    bus_b.go = 1'b0; bus_b.enabled = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus_b.fire !== 3'd5) begin
        errors++; $display("FAIL gate_idle[%0d]: got %0d expected 5", k, bus_b.fire);
      end
    end
    checks++;
    if (bus_b.fire_count !== 32'd4) begin
      errors++; $display("FAIL gate_count_hold: got %0d expected 4", bus_b.fire_count);
    end
    bus_b.go = 1'b1;
    tick();
    checks++;
    if (bus_b.fire !== 3'd2 || bus_b.forced !== 1'b1) begin
      errors++; $display("FAIL gate_forced: got fire %0d forced %0d expected fire 2 forced 1",
                         bus_b.fire, bus_b.forced);
    end
    tick();
    checks++;
    if (bus_b.fire !== 3'd2 || bus_b.forced !== 1'b0) begin
      errors++; $display("FAIL gate_after: got fire %0d forced %0d expected fire 2 forced 0",
                         bus_b.fire, bus_b.forced);
    end
    checks++;
    if (bus_b.fire_count !== 32'd6) begin
      errors++; $display("FAIL gate_count: got %0d expected 6", bus_b.fire_count);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_async_reset();
    test_starvation();
    test_go_gating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fire_scheduler.md
# fire_scheduler

Drives the `fire` bus of the synchronous circuit-plus-spec model from a registered, fair choice among the currently enabled transitions. Transition indices are inputs first, then stateful gates in netlist order. This matches the ordering the spec-compliance monitor and the circuit wrapper use. The block replaces the free `fire` input in simulation and in bounded runs, and it guarantees that no enabled transition starves.

## Interface
Parameters:
- `N`, 4: number of transitions (inputs plus stateful gates); legal range 1..64.
- `FW`, `$clog2(N+2)`: width of `fire`.
- `MAX_WAIT`, 8: cycles an enabled transition may be passed over before it is forced; must be ≥1.
- `SEED`, 16'hACE1: initial value of the LFSR; a value of 0 is replaced by 1.

Ports:
- `clk`, input, 1: model clock.
- `reset`, input, 1: asynchronous, active-low (0 = reset).
- `go`, input, 1: scheduling enable; when 0 the next `fire` is IDLE.
- `mode`, input, 1: 0 = round-robin, 1 = pseudo-random start point.
- `enabled`, input, N: bit i = 1 when transition i may fire this cycle. For an input this is `can_rise`/`can_fall`; for a gate it is `_ena`.
- `fire`, output, FW: registered selected transition index, or IDLE = N+1. Code N is never driven.
- `forced`, output, 1: registered; 1 when the current `fire` came from the age override.
- `fire_count`, output, 32: number of non-IDLE selections since reset; wraps at 2^32.

## Operation
- Registered state:
  - `fire`
  - `forced`
  - `ptr` (0..N-1)
  - `lfsr` (16-bit Galois, taps 16,14,13,11)
  - `age[i]` (saturating at MAX_WAIT)
  - `fire_count`
- Reset (async, `reset`=0):
  - `fire`=IDLE, `forced`=0, `ptr`=0, `lfsr`=SEED (or 1), all `age`=0, `fire_count`=0.
- Each posedge with `reset`=1: `lfsr` advances unconditionally. `sel` is computed from `enabled` sampled at that edge using the priority order below; the first rule that matches decides.
  1. `go`=0 or `enabled`=0: `sel`=IDLE, `forced`=0.
  2. Any enabled i with `age[i]`==MAX_WAIT: `sel` = lowest such i, `forced`=1.
  3. `mode`=0: `sel` = first enabled index scanning `ptr`, `ptr+1`, … with wrap modulo N. `forced`=0.
  4. `mode`=1: same scan, but starting at `lfsr % N` (pre-advance value). `forced`=0.
- Updates on that edge:
  - `fire` <= `sel`.
  - If `sel`≠IDLE: `ptr` <= (`sel`+1) mod N, and `fire_count`++.
  - Otherwise `ptr` holds.
- Per-transition age update on that edge:
  - `age[i]` <= 0 if i==`sel` or `enabled[i]`==0.
  - Otherwise `age[i]` <= min(`age[i]`+1, MAX_WAIT). This includes the case `go`=0, so ages keep counting while scheduling is paused.
- When `go` returns to 1, any transition still at MAX_WAIT is forced first.
- N=1: `ptr` stays 0; the only selectable value is 0 or IDLE.

## Timing
- One-cycle latency: `enabled` sampled at edge k determines `fire` during cycle k+1.
- `fire` is stable for the whole cycle, so the monitor's "fire equals fire sampled on negedge" constraint holds by construction.
- If the selected transition is no longer enabled when it is consumed, the model takes no step. The scheduler does not retract a selection.
- Fairness bound: a continuously enabled transition is selected within MAX_WAIT+N cycles. With `go`=1 throughout, `fire` never exceeds N+1.
- Reset asserted mid-run: outputs drop to their reset values immediately, with no clock edge needed. The first selection appears on the first posedge after `reset` rises, visible in the following cycle.

## Test plan
- Reset check: N=4. Hold `reset`=0 with arbitrary inputs -> `fire`=5, `forced`=0, `fire_count`=0. Release `reset` with `enabled`=0 -> `fire` stays 5.
- Round-robin: N=4, `mode`=0, `enabled`=4'b1111 constant -> `fire` sequence 0,1,2,3,0,1 starting the cycle after `go` rises. `forced` stays 0 and `fire_count` increments every cycle.
- Skip and wrap: `enabled`=4'b1001, `ptr`=1 -> `fire`=3, then 0, then 3, then 0.
- Starvation override: N=4, MAX_WAIT=2, `mode`=1, `enabled`=4'b1111, with a seed that keeps skipping transition 2 -> by the third cycle of waiting `fire`=2 and `forced`=1. `age[2]` clears the following edge.
- Go gating: `enabled`=4'b0100 with `go`=0 for 5 cycles -> `fire`=5 throughout. After `go`=1, the next `fire`=2 with `forced`=1 (age saturated at MAX_WAIT=2).
- Async reset mid-operation: pull `reset` low between clock edges while `fire`=1 -> `fire`=5 without a clock edge. After release, round-robin restarts at index 0.
